ipif_register_bank: RTL and testbench

Parametrised IPIF register bank, the successor to the plain parameter decoder: it maps N_REG words of AXI-Lite/IPIF address space onto a flat parameter vector for the fabric. It adds:
- per-bit access modes: read/write, read-only status, write-1-to-clear sticky event, and self-reset;
- byte-enable writes;
- an optional shadow/commit stage;
- error signalling;
- single-ack handshakes.

It sits between the AXI-Lite IPIF slave and the user logic of every FTBF IP core.

---
 rtl/ipif_register_bank.sv | 219 +++++++++++++++++++++
 tb/tb_ipif_register_bank.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ipif_register_bank.sv
// ipif_register_bank
//
// Maps N_REG words of IPIF register space onto a flat parameter vector for
// user logic. Each bit belongs to one class, resolved with the priority
// RO > W1C > SELF_RESET > RW:
//   RW         : written with byte enables; optionally via a shadow copy that
//                is applied to the active copy on commit_in
//   SELF_RESET : written like RW (never shadowed); reverts to DEFAULTS once
//                parameters_in disagrees with DEFAULTS
//   RO         : parameters_out holds DEFAULTS, reads return status_in
//   W1C        : sticky, set by event_in, cleared by writing 1
//
// Handshake: a write (read) is accepted in any cycle where some wrce (rdce)
// bit is set and wrack (rdack) is low. The ack is registered, so it is high
// for exactly the cycle after acceptance; a chip enable still held during
// that ack cycle is ignored, giving one action and one ack per transfer.
// Error is registered alongside the ack and is never high without an ack.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   IPIF_bus2ip_addr      byte address (decoded only when USE_ONEHOT_READ=0)
//   IPIF_bus2ip_data/_be  write data and byte enables
//   IPIF_bus2ip_rdce/wrce per-register read/write chip enables
//   IPIF_ip2bus_data      registered read data
//   IPIF_ip2bus_rdack/wrack/error  single-cycle acks and error flag
//   parameters_out        register contents, word i at [i*W +: W]
//   parameters_in         readback of RW/self-reset bits
//   status_in             live values for RO bits
//   event_in              set pulses for W1C bits
//   commit_in             shadow -> active (SHADOWED=1)
module ipif_register_bank #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int N_REG              = 4,
    parameter int USE_ONEHOT_READ    = 1,
    parameter int SHADOWED           = 0,
    parameter logic [N_REG*C_S_AXI_DATA_WIDTH-1:0] DEFAULTS        = '0,
    parameter logic [N_REG*C_S_AXI_DATA_WIDTH-1:0] SELF_RESET_MASK = '0,
    parameter logic [N_REG*C_S_AXI_DATA_WIDTH-1:0] RO_MASK         = '0,
    parameter logic [N_REG*C_S_AXI_DATA_WIDTH-1:0] W1C_MASK        = '0
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]         IPIF_bus2ip_addr,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]         IPIF_bus2ip_data,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]       IPIF_bus2ip_be,
    input  logic [N_REG-1:0]                      IPIF_bus2ip_rdce,
    input  logic [N_REG-1:0]                      IPIF_bus2ip_wrce,
    output logic [C_S_AXI_DATA_WIDTH-1:0]         IPIF_ip2bus_data,
    output logic                                  IPIF_ip2bus_rdack,
    output logic                                  IPIF_ip2bus_wrack,
    output logic                                  IPIF_ip2bus_error,
    output logic [N_REG*C_S_AXI_DATA_WIDTH-1:0]   parameters_out,
    input  logic [N_REG*C_S_AXI_DATA_WIDTH-1:0]   parameters_in,
    input  logic [N_REG*C_S_AXI_DATA_WIDTH-1:0]   status_in,
    input  logic [N_REG*C_S_AXI_DATA_WIDTH-1:0]   event_in,
    input  logic                                  commit_in
);

    localparam int W  = C_S_AXI_DATA_WIDTH;
    localparam int NB = W / 8;
    localparam int PW = N_REG * W;
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int IW = (N_REG > 1) ? $clog2(N_REG) : 1;

    // Exclusive bit classes after applying the precedence order.
    localparam logic [PW-1:0] RO_M  = RO_MASK;
    localparam logic [PW-1:0] W1C_M = W1C_MASK & ~RO_MASK;
    localparam logic [PW-1:0] SR_M  = SELF_RESET_MASK & ~RO_MASK & ~W1C_MASK;
    localparam logic [PW-1:0] RW_M  = ~(RO_M | W1C_M | SR_M);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PW-1:0] active_q, active_d;
    logic [PW-1:0] shadow_q, shadow_d;
    logic [PW-1:0] sticky_q, sticky_d;
    logic [W-1:0]  rdata_q,  rdata_d;
    logic          rdack_q, wrack_q, err_q, err_d;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    function automatic logic [IW-1:0] ce_index(input logic [N_REG-1:0] ce);
        logic [IW-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REG; i++) begin
            if (ce[i]) idx = IW'(i);
        end
        return idx;
    endfunction

    function automatic logic multi_hot(input logic [N_REG-1:0] ce);
        return (ce & (ce - N_REG'(1))) != '0;
    endfunction

    logic [AW-1:0] addr_word;
    logic          addr_oor;
    logic          wr_acc, rd_acc;
    logic          wr_err, rd_err;
    logic          wr_go;
    logic [IW-1:0] wr_idx, rd_idx;

    assign addr_word = IPIF_bus2ip_addr >> 2;
    assign addr_oor  = addr_word >= AW'(N_REG);

    assign wr_acc = (|IPIF_bus2ip_wrce) & ~wrack_q;
    assign rd_acc = (|IPIF_bus2ip_rdce) & ~rdack_q;

    always_comb begin
        if (USE_ONEHOT_READ != 0) begin
            wr_idx = ce_index(IPIF_bus2ip_wrce);
            rd_idx = ce_index(IPIF_bus2ip_rdce);
            wr_err = multi_hot(IPIF_bus2ip_wrce);
            rd_err = multi_hot(IPIF_bus2ip_rdce);
        end else begin
            wr_idx = addr_word[IW-1:0];
            rd_idx = addr_word[IW-1:0];
            wr_err = addr_oor;
            rd_err = addr_oor;
        end
    end

    assign wr_go = wr_acc & ~wr_err;

    // ------------------------------------------------------------------
    // Write mask: all bits of the enabled bytes of the target word
    // ------------------------------------------------------------------
    logic [PW-1:0] wr_bits;
    logic [PW-1:0] wdata_rep;

    assign wdata_rep = {N_REG{IPIF_bus2ip_data}};

    always_comb begin
        wr_bits = '0;
        for (int i = 0; i < N_REG; i++) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_go && wr_idx == IW'(i) && IPIF_bus2ip_be[b])
                    wr_bits[i*W + b*8 +: 8] = 8'hFF;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state for register bits
    // ------------------------------------------------------------------
    logic [PW-1:0] sr_rev, sr_hold, sr_new, rw_new;

    always_comb begin
        // Self-reset bits revert wherever the user logic reports a value
        // differing from the default; a write to the byte takes priority.
        sr_rev  = SR_M & (parameters_in ^ DEFAULTS);
        sr_hold = (active_q & ~sr_rev) | (DEFAULTS & sr_rev);
        sr_new  = (sr_hold & ~wr_bits) | (wdata_rep & wr_bits);

        if (SHADOWED != 0) begin
            // Commit uses the shadow value from before this cycle's write.
            rw_new   = commit_in ? shadow_q : active_q;
            shadow_d = (shadow_q & ~wr_bits) | (wdata_rep & wr_bits);
        end else begin
            rw_new   = (active_q & ~wr_bits) | (wdata_rep & wr_bits);
            shadow_d = shadow_q;
        end

        active_d = (rw_new & RW_M) | (sr_new & SR_M) | (DEFAULTS & ~(RW_M | SR_M));

        // Set wins over a same-cycle clear.
        sticky_d = ((sticky_q & ~(wr_bits & wdata_rep)) | event_in) & W1C_M;
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [PW-1:0] rd_view;
    logic [W-1:0]  rd_word;

    assign rd_view = (status_in & RO_M) | (sticky_q & W1C_M)
                   | (parameters_in & ~(RO_M | W1C_M));

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < N_REG; i++) begin
            if (rd_idx == IW'(i)) rd_word = rd_view[i*W +: W];
        end
        rdata_d = (rd_acc && !rd_err) ? rd_word : '0;
        err_d   = (rd_acc & rd_err) | (wr_acc & wr_err);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q <= DEFAULTS;
            shadow_q <= DEFAULTS;
            sticky_q <= '0;
            rdata_q  <= '0;
            rdack_q  <= 1'b0;
            wrack_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            active_q <= active_d;
            shadow_q <= shadow_d;
            sticky_q <= sticky_d;
            rdata_q  <= rdata_d;
            rdack_q  <= rd_acc;
            wrack_q  <= wr_acc;
            err_q    <= err_d;
        end
    end

    assign parameters_out    = (active_q & (RW_M | SR_M)) | (DEFAULTS & RO_M)
                             | (sticky_q & W1C_M);
    assign IPIF_ip2bus_data  = rdata_q;
    assign IPIF_ip2bus_rdack = rdack_q;
    assign IPIF_ip2bus_wrack = wrack_q;
    assign IPIF_ip2bus_error = err_q;

endmodule

// File: tb/tb_ipif_register_bank.sv
// Directed bench for ipif_register_bank. Instance u_dut0 uses one-hot
// decode with RW, RO, W1C and self-reset bits; u_dut1 uses address decode
// with the shadow/commit stage. Inputs change and outputs are sampled on
// the falling clock edge.
module tb_ipif_register_bank;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int PW = N * W;
    localparam int AW = 32;

    localparam logic [PW-1:0] DEF0 = {32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h1234_5678};
    localparam logic [PW-1:0] RO0  = {32'hFFFF_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    localparam logic [PW-1:0] W1C0 = {32'h0000_0000, 32'h0000_00FF, 32'h0000_0000, 32'h0000_0000};
    localparam logic [PW-1:0] SR0  = {32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // ---------------- dut0 signals ----------------
    logic [AW-1:0] addr0;
    logic [W-1:0]  wdata0, rdata0;
    logic [3:0]    be0;
    logic [N-1:0]  rdce0, wrce0;
    logic          rdack0, wrack0, err0, commit0, loop0;
    logic [PW-1:0] pout0, pin0, pin0_drv, status0, event0;

    assign pin0 = loop0 ? pout0 : pin0_drv;

    // ---------------- dut1 signals ----------------
    logic [AW-1:0] addr1;
    logic [W-1:0]  wdata1, rdata1;
    logic [3:0]    be1;
    logic [N-1:0]  rdce1, wrce1;
    logic          rdack1, wrack1, err1, commit1;
    logic [PW-1:0] pout1, pin1, status1, event1;

    assign pin1 = pout1;

    ipif_register_bank #(
        .C_S_AXI_DATA_WIDTH(W), .C_S_AXI_ADDR_WIDTH(AW), .N_REG(N),
        .USE_ONEHOT_READ(1), .SHADOWED(0),
        .DEFAULTS(DEF0), .SELF_RESET_MASK(SR0), .RO_MASK(RO0), .W1C_MASK(W1C0)
    ) u_dut0 (
        .clk(clk), .reset(reset),
        .IPIF_bus2ip_addr(addr0), .IPIF_bus2ip_data(wdata0), .IPIF_bus2ip_be(be0),
        .IPIF_bus2ip_rdce(rdce0), .IPIF_bus2ip_wrce(wrce0),
        .IPIF_ip2bus_data(rdata0), .IPIF_ip2bus_rdack(rdack0),
        .IPIF_ip2bus_wrack(wrack0), .IPIF_ip2bus_error(err0),
        .parameters_out(pout0), .parameters_in(pin0), .status_in(status0),
        .event_in(event0), .commit_in(commit0)
    );

    ipif_register_bank #(
        .C_S_AXI_DATA_WIDTH(W), .C_S_AXI_ADDR_WIDTH(AW), .N_REG(N),
        .USE_ONEHOT_READ(0), .SHADOWED(1)
    ) u_dut1 (
        .clk(clk), .reset(reset),
        .IPIF_bus2ip_addr(addr1), .IPIF_bus2ip_data(wdata1), .IPIF_bus2ip_be(be1),
        .IPIF_bus2ip_rdce(rdce1), .IPIF_bus2ip_wrce(wrce1),
        .IPIF_ip2bus_data(rdata1), .IPIF_ip2bus_rdack(rdack1),
        .IPIF_ip2bus_wrack(wrack1), .IPIF_ip2bus_error(err1),
        .parameters_out(pout1), .parameters_in(pin1), .status_in(status1),
        .event_in(event1), .commit_in(commit1)
    );

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wr0(input logic [N-1:0] ce, input logic [W-1:0] d, input logic [3:0] be,
                       input logic exp_err, input int hold);
        @(negedge clk);
        wrce0 = ce; wdata0 = d; be0 = be;
        @(negedge clk);
        check("wr0_ack", wrack0, 1'b1);
        check("wr0_err", err0, exp_err);
        if (hold > 1) begin
            @(negedge clk);
            check("wr0_single_ack", wrack0, 1'b0);
        end
        wrce0 = '0; be0 = '0;
    endtask

    task automatic rd0(input logic [N-1:0] ce, input logic [W-1:0] exp_d, input logic exp_err);
        @(negedge clk);
        rdce0 = ce;
        @(negedge clk);
        check("rd0_ack", rdack0, 1'b1);
        check("rd0_data", rdata0, exp_d);
        check("rd0_err", err0, exp_err);
        rdce0 = '0;
    endtask

    task automatic wr1(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [3:0] be,
                       input logic exp_err, input logic cmt);
        @(negedge clk);
        addr1 = a; wrce1 = 4'b0001; wdata1 = d; be1 = be; commit1 = cmt;
        @(negedge clk);
        check("wr1_ack", wrack1, 1'b1);
        check("wr1_err", err1, exp_err);
        wrce1 = '0; be1 = '0; commit1 = 1'b0;
    endtask

    task automatic rd1(input logic [AW-1:0] a, input logic [W-1:0] exp_d, input logic exp_err);
        @(negedge clk);
        addr1 = a; rdce1 = 4'b0001;
        @(negedge clk);
        check("rd1_ack", rdack1, 1'b1);
        check("rd1_data", rdata1, exp_d);
        check("rd1_err", err1, exp_err);
        rdce1 = '0;
    endtask

    task automatic commit_pulse();
        @(negedge clk);
        commit1 = 1'b1;
        @(negedge clk);
        commit1 = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        addr0 = '0; wdata0 = '0; be0 = '0; rdce0 = '0; wrce0 = '0; commit0 = 1'b0;
        loop0 = 1'b1; pin0_drv = '0; status0 = '0; event0 = '0;
        addr1 = '0; wdata1 = '0; be1 = '0; rdce1 = '0; wrce1 = '0; commit1 = 1'b0;
        status1 = '0; event1 = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_pout0", pout0, DEF0);
        check("rst_pout1", pout1, '0);
        check("rst_rdack", rdack0, 1'b0);
        check("rst_wrack", wrack0, 1'b0);
        check("rst_err", err0, 1'b0);
        check("rst_rdata", rdata0, '0);
        reset = 1'b0;

        // Default readback
        rd0(4'b0001, 32'h1234_5678, 1'b0);

        // Byte-enable write, wrce held for two cycles
        wr0(4'b0010, 32'hAABB_CCDD, 4'b0101, 1'b0, 2);
        check("be_write_word1", pout0[63:32], 32'h00BB_00DD);
        rd0(4'b0010, 32'h00BB_00DD, 1'b0);

        // W1C: set by event
        @(negedge clk);
        event0[67] = 1'b1;
        @(negedge clk);
        event0 = '0;
        check("w1c_set", pout0[95:64], 32'h0000_0008);
        // Clear and set together: set wins
        @(negedge clk);
        wrce0 = 4'b0100; wdata0 = 32'h0000_0008; be0 = 4'b0001; event0[67] = 1'b1;
        @(negedge clk);
        check("w1c_race_ack", wrack0, 1'b1);
        check("w1c_set_wins", pout0[95:64], 32'h0000_0008);
        wrce0 = '0; be0 = '0; event0 = '0;
        rd0(4'b0100, 32'h0000_0008, 1'b0);
        // Clear alone
        wr0(4'b0100, 32'h0000_0008, 4'b0001, 1'b0, 1);
        check("w1c_clear", pout0[95:64], 32'h0000_0000);

        // Self-reset bit 0 of word 3
        @(negedge clk);
        loop0 = 1'b0;
        pin0_drv = {32'h0000_0000, 32'h0000_0000, 32'h00BB_00DD, 32'h1234_5678};
        wr0(4'b1000, 32'h0000_0001, 4'b0001, 1'b0, 1);
        check("sr_written", pout0[127:96], 32'h0000_0001);
        @(negedge clk);
        check("sr_hold", pout0[127:96], 32'h0000_0001);
        pin0_drv[96] = 1'b1;
        @(negedge clk);
        check("sr_revert", pout0[127:96], 32'h0000_0000);

        // RO bits ignore writes and read from status_in
        wr0(4'b1000, 32'hABCD_0000, 4'b1100, 1'b0, 1);
        check("ro_no_write", pout0[127:96], 32'h0000_0000);
        status0[127:96] = 32'h5A5A_1234;
        rd0(4'b1000, 32'h5A5A_0001, 1'b0);
        pin0_drv[96] = 1'b0;
        loop0 = 1'b1;

        // One-hot error: two chip enables
        wr0(4'b0011, 32'hFFFF_FFFF, 4'b1111, 1'b1, 1);
        check("err_no_change", pout0,
              {32'h0000_0000, 32'h0000_0000, 32'h00BB_00DD, 32'h1234_5678});
        rd0(4'b0101, 32'h0000_0000, 1'b1);

        // Simultaneous read (reg0) and write (reg1)
        @(negedge clk);
        wrce0 = 4'b0010; wdata0 = 32'h1122_3344; be0 = 4'b1111; rdce0 = 4'b0001;
        @(negedge clk);
        check("sim_wrack", wrack0, 1'b1);
        check("sim_rdack", rdack0, 1'b1);
        check("sim_err", err0, 1'b0);
        check("sim_rdata", rdata0, 32'h1234_5678);
        check("sim_word1", pout0[63:32], 32'h1122_3344);
        wrce0 = '0; be0 = '0; rdce0 = '0;
        @(negedge clk);
        check("ack_drop", {wrack0, rdack0, err0}, 3'b000);

        // Shadowed instance, address decode
        wr1(32'h0, 32'h0000_0005, 4'b1111, 1'b0, 1'b0);
        check("shadow_hidden", pout1[31:0], 32'h0);
        commit_pulse();
        check("commit_5", pout1[31:0], 32'h0000_0005);
        rd1(32'h0, 32'h0000_0005, 1'b0);
        wr1(32'h0, 32'h0000_0007, 4'b1111, 1'b0, 1'b1);
        check("commit_prewrite", pout1[31:0], 32'h0000_0005);
        commit_pulse();
        check("commit_7", pout1[31:0], 32'h0000_0007);
        wr1(32'hC, 32'h0000_CAFE, 4'b0011, 1'b0, 1'b0);
        commit_pulse();
        check("commit_last_reg", pout1, {32'h0000_CAFE, 64'h0, 32'h0000_0007});
        // Address out of range
        wr1(32'h10, 32'hFFFF_FFFF, 4'b1111, 1'b1, 1'b0);
        commit_pulse();
        check("addr_err_no_change", pout1, {32'h0000_CAFE, 64'h0, 32'h0000_0007});
        rd1(32'h10, 32'h0, 1'b1);

        // Reset in the middle of a write: no ack, defaults restored
        @(negedge clk);
        wrce0 = 4'b0010; wdata0 = 32'hFFFF_FFFF; be0 = 4'b1111;
        #2 reset = 1'b1;
        @(negedge clk);
        check("abort_wrack", wrack0, 1'b0);
        check("abort_err", err0, 1'b0);
        check("abort_pout0", pout0, DEF0);
        check("abort_pout1", pout1, '0);
        wrce0 = '0; be0 = '0;
        reset = 1'b0;
        @(negedge clk);
        check("abort_no_late_ack", wrack0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
